// File: rtl/fma_mant_adder.sv
// FMA mantissa adder: 3:2 CSA of aligned addend with Wallace sum/carry, 75-bit add,
// sign-magnitude conversion, two-stage valid/ready pipeline. Macro FMA_ADD_LZC_EN adds a registered LZC.
module fma_mant_adder #(
  parameter int PARM_EXP   = 8,
  parameter int PARM_MANT  = 23,
  parameter int PARM_ADD_W = 74,
  parameter int PARM_LZC_W = 7
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [PARM_ADD_W:0]        A_Mant_aligned_i,
  input  logic [2*PARM_MANT+1:0]     Wallace_sum_i,
  input  logic [2*PARM_MANT+1:0]     Wallace_carry_i,
  input  logic [PARM_EXP+1:0]        Exp_aligned_i,
  input  logic                       Sign_aligned_i,
  input  logic                       Sticky_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [PARM_ADD_W-1:0]      Mant_sum_o,
  output logic [PARM_EXP+1:0]        Exp_o,
  output logic                       Sign_o,
  output logic                       Sign_change_o,
  output logic                       Sticky_o,
  output logic                       Zero_o,
  output logic [PARM_LZC_W-1:0]      Lzc_o
);

  localparam int RW = PARM_ADD_W + 1;

  typedef struct packed {
    logic [PARM_ADD_W-1:0] sum;
    logic [PARM_ADD_W-1:0] carry;
    logic                  sub;
    logic [PARM_EXP+1:0]   exp;
    logic                  sign;
    logic                  sticky;
  } s1_t;

  typedef struct packed {
    logic [PARM_ADD_W-1:0] mant;
    logic [PARM_EXP+1:0]   exp;
    logic                  sign;
    logic                  sign_change;
    logic                  sticky;
    logic                  zero;
  } s2_t;

  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d;

  logic s2_adv, s1_adv, accept, s2_load;

  assign s2_adv  = ~s2_valid_q | ready_i;
  assign s1_adv  = ~s1_valid_q | s2_adv;
  assign accept  = valid_i & s1_adv;
  assign s2_load = s2_adv & s1_valid_q;
  assign ready_o = s1_adv;

  logic [PARM_ADD_W-1:0] op_a, op_b, op_c;
  logic [PARM_ADD_W-2:0] csa_maj;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    op_a    = A_Mant_aligned_i[PARM_ADD_W-1:0];
    op_b    = PARM_ADD_W'(Wallace_sum_i);
    op_c    = PARM_ADD_W'(Wallace_carry_i);
    csa_maj = (op_a[PARM_ADD_W-2:0] & op_b[PARM_ADD_W-2:0]) |
              (op_a[PARM_ADD_W-2:0] & op_c[PARM_ADD_W-2:0]) |
              (op_b[PARM_ADD_W-2:0] & op_c[PARM_ADD_W-2:0]);

    s1_valid_d = s1_adv ? valid_i : s1_valid_q;
    s1_d       = s1_q;
    if (accept) begin
      s1_d.sum    = op_a ^ op_b ^ op_c;
      s1_d.carry  = {csa_maj, 1'b0};
      s1_d.sub    = A_Mant_aligned_i[PARM_ADD_W];
      s1_d.exp    = Exp_aligned_i;
      s1_d.sign   = Sign_aligned_i;
      s1_d.sticky = Sticky_i;
    end
  end

  logic [PARM_ADD_W:0]   raw;
  logic                  raw_neg;
  logic [PARM_ADD_W-1:0] mag;
  logic                  mag_zero;

  always_comb begin
    // Only the sum vector carries the addend's sign; the product vectors are narrower
    // than the datapath, so the carry vector's dropped top bit is always 0.
    raw      = {s1_q.sub, s1_q.sum} + {1'b0, s1_q.carry} + RW'(s1_q.sub);
    raw_neg  = raw[PARM_ADD_W];
    mag      = raw_neg ? (~raw[PARM_ADD_W-1:0] + PARM_ADD_W'(1)) : raw[PARM_ADD_W-1:0];
    mag_zero = (mag == '0);

    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    s2_d       = s2_q;
    if (s2_load) begin
      s2_d.mant        = mag;
      s2_d.exp         = s1_q.exp;
      s2_d.sign_change = raw_neg;
      s2_d.sign        = mag_zero ? (s1_q.sign & ~s1_q.sub) : (s1_q.sign ^ raw_neg);
      s2_d.sticky      = s1_q.sticky;
      s2_d.zero        = mag_zero;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: data registers are reset too, so every output reads 0 during reset.
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

  assign valid_o       = s2_valid_q;
  assign Mant_sum_o    = s2_q.mant;
  assign Exp_o         = s2_q.exp;
  assign Sign_o        = s2_q.sign;
  assign Sign_change_o = s2_q.sign_change;
  assign Sticky_o      = s2_q.sticky;
  assign Zero_o        = s2_q.zero;

`ifdef FMA_ADD_LZC_EN
  logic [PARM_LZC_W-1:0] lzc_q, lzc_d;

  // Highest set bit wins; an all-zero magnitude reports the full width.
  function automatic logic [PARM_LZC_W-1:0] lzc_f(input logic [PARM_ADD_W-1:0] v);
    lzc_f = PARM_LZC_W'(PARM_ADD_W);
    for (int i = 0; i < PARM_ADD_W; i++) begin
      if (v[i]) lzc_f = PARM_LZC_W'(PARM_ADD_W - 1 - i);
    end
  endfunction

  always_comb begin
    lzc_d = lzc_q;
    if (s2_load) lzc_d = lzc_f(mag);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lzc_q <= '0;
    else         lzc_q <= lzc_d;
  end

  assign Lzc_o = lzc_q;
`else
  assign Lzc_o = '0;
`endif

endmodule

// File: tb/tb_fma_mant_adder.sv
// Self-checking bench for fma_mant_adder: directed vectors, stall/reset scenarios and a
// randomized valid/ready stream scored against an arithmetic reference model.
module tb_fma_mant_adder;

`ifdef FMA_ADD_LZC_EN
  localparam bit LZC_ON = 1'b1;
`else
  localparam bit LZC_ON = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        valid_i, ready_o, valid_o, ready_i;
  logic [74:0] A_Mant_aligned_i;
  logic [47:0] Wallace_sum_i, Wallace_carry_i;
  logic [9:0]  Exp_aligned_i, Exp_o;
  logic        Sign_aligned_i, Sticky_i;
  logic [73:0] Mant_sum_o;
  logic        Sign_o, Sign_change_o, Sticky_o, Zero_o;
  logic [6:0]  Lzc_o;

  int n_checks = 0;
  int n_errors = 0;

  fma_mant_adder dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .A_Mant_aligned_i(A_Mant_aligned_i), .Wallace_sum_i(Wallace_sum_i),
    .Wallace_carry_i(Wallace_carry_i), .Exp_aligned_i(Exp_aligned_i),
    .Sign_aligned_i(Sign_aligned_i), .Sticky_i(Sticky_i), .valid_o(valid_o),
    .ready_i(ready_i), .Mant_sum_o(Mant_sum_o), .Exp_o(Exp_o), .Sign_o(Sign_o),
    .Sign_change_o(Sign_change_o), .Sticky_o(Sticky_o), .Zero_o(Zero_o), .Lzc_o(Lzc_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] lz_exp(input int n);
    return LZC_ON ? 7'(n) : 7'd0;
  endfunction

  function automatic logic [94:0] pack_dut();
    return {Mant_sum_o, Exp_o, Sign_o, Sign_change_o, Sticky_o, Zero_o, Lzc_o};
  endfunction

  // Reference: treat A as a 75-bit two's-complement addend, add the product and the
  // subtract carry-in, then take magnitude/sign of the result.
  function automatic logic [94:0] model(input logic [74:0] a, input logic [47:0] s,
                                        input logic [47:0] c, input logic [9:0] e,
                                        input logic sg, input logic st);
    logic [74:0] r;
    logic [73:0] mag, t, zero74;
    logic        neg, z, so;
    int          len;
    zero74 = '0;
    r   = a + {27'd0, s} + {27'd0, c} + {74'd0, a[74]};
    neg = r[74];
    mag = neg ? (zero74 - r[73:0]) : r[73:0];
    z   = (mag == zero74);
    so  = z ? (sg & ~a[74]) : (sg ^ neg);
    len = 0;
    t   = mag;
    while (t != zero74) begin
      t = t >> 1;
      len++;
    end
    return {mag, e, so, neg, st, z, lz_exp(74 - len)};
  endfunction

  task automatic drive_op(input logic [74:0] a, input logic [47:0] s, input logic [47:0] c,
                          input logic [9:0] e, input logic sg, input logic st);
    A_Mant_aligned_i = a;
    Wallace_sum_i    = s;
    Wallace_carry_i  = c;
    Exp_aligned_i    = e;
    Sign_aligned_i   = sg;
    Sticky_i         = st;
  endtask

  task automatic gen_op();
    logic [95:0] w;
    logic [63:0] ws, wc;
    logic [73:0] a74;
    logic [47:0] s48, c48;
    logic        sub;
    w   = {$urandom(), $urandom(), $urandom()};
    ws  = {$urandom(), $urandom()};
    wc  = {$urandom(), $urandom()};
    s48 = ws[47:0] >> $urandom_range(47);
    c48 = wc[47:0] >> $urandom_range(47);
    sub = 1'($urandom_range(1));
    a74 = w[73:0] >> $urandom_range(73);
    if (sub) a74 = ~a74;
    if ($urandom_range(7) == 0) begin
      sub = 1'b1;
      a74 = ~({26'd0, s48} + {26'd0, c48});
    end
    drive_op({sub, a74}, s48, c48, 10'($urandom()), 1'($urandom_range(1)), 1'($urandom_range(1)));
  endtask

  // One isolated beat with ready_i=1; returns the output beat and cycles to valid_o.
  task automatic send_one(input logic [74:0] a, input logic [47:0] s, input logic [47:0] c,
                          input logic [9:0] e, input logic sg, input logic st,
                          output logic [94:0] beat, output int lat);
    @(posedge clk_i); #1;
    drive_op(a, s, c, e, sg, st);
    valid_i = 1'b1;
    ready_i = 1'b1;
    @(negedge clk_i);
    check("accept_ready", ready_o, 1);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 10) begin
      @(posedge clk_i); #1;
      lat++;
    end
    if (!valid_o) check("timeout_valid", valid_o, 1);
    beat = pack_dut();
  endtask

  task automatic run_stream(input int n_ops, input bit stall_mode);
    logic [94:0] q[$];
    logic [94:0] snap, exp_b;
    bit          was_stalled, accepted;
    int          sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    was_stalled = 1'b0;
    accepted    = 1'b0;
    gen_op();
    while (got < n_ops && cyc < 4000) begin
      @(posedge clk_i); #1;
      if (accepted) gen_op();
      valid_i = (sent < n_ops) && (stall_mode || $urandom_range(3) != 0);
      ready_i = stall_mode ? !(cyc >= 2 && cyc <= 5) : ($urandom_range(2) != 0);
      @(negedge clk_i);
      if (was_stalled) check("hold_stable", {valid_o, pack_dut()}, {1'b1, snap});
      if (stall_mode && !ready_i && sent == 2) check("ready_o_stall", ready_o, 0);
      was_stalled = valid_o && !ready_i;
      snap        = pack_dut();
      if (valid_o && ready_i) begin
        if (q.size() == 0) check("spurious_beat", 1, 0);
        else begin
          exp_b = q.pop_front();
          check("beat", pack_dut(), exp_b);
        end
        got++;
      end
      accepted = valid_i && ready_o;
      if (accepted) begin
        q.push_back(model(A_Mant_aligned_i, Wallace_sum_i, Wallace_carry_i,
                          Exp_aligned_i, Sign_aligned_i, Sticky_i));
        sent++;
      end
      cyc++;
    end
    check("stream_count", got, n_ops);
    check("queue_empty", q.size(), 0);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    check("no_duplicate", valid_o, 0);
  endtask

  logic [94:0] beat;
  int          lat;

  initial begin
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    drive_op('0, '0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_valid_o", valid_o, 0);
    check("reset_outputs", pack_dut(), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check("reset_ready_o", ready_o, 1);

    send_one(75'd0, 48'd5, 48'd3, 10'h0A5, 1'b0, 1'b1, beat, lat);
    check("t1_beat", beat, {74'd8, 10'h0A5, 1'b0, 1'b0, 1'b1, 1'b0, lz_exp(70)});
    check("t1_latency", lat, 2);

    send_one({1'b1, ~74'd10}, 48'd4, 48'd0, 10'h000, 1'b0, 1'b0, beat, lat);
    check("t2_beat", beat, {74'd6, 10'h000, 1'b1, 1'b1, 1'b0, 1'b0, lz_exp(71)});

    send_one({1'b1, ~74'd7}, 48'd7, 48'd0, 10'h000, 1'b1, 1'b0, beat, lat);
    check("t3_cancel", beat, {74'd0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1, lz_exp(74)});

    run_stream(5, 1'b1);

    // Two beats in flight, then an asynchronous reset between clock edges.
    @(posedge clk_i); #1;
    drive_op(75'd0, 48'd100, 48'd0, 10'h011, 1'b0, 1'b0);
    valid_i = 1'b1;
    ready_i = 1'b0;
    @(posedge clk_i); #1;
    drive_op(75'd0, 48'd200, 48'd0, 10'h022, 1'b0, 1'b0);
    @(posedge clk_i); #3;
    check("pre_reset_valid", valid_o, 1);
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    #1;
    check("reset_async_valid", valid_o, 0);
    check("reset_async_clear", pack_dut(), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check("post_reset_ready", ready_o, 1);
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      check("post_reset_idle", valid_o, 0);
    end
    send_one(75'd0, 48'h123, 48'h1, 10'h055, 1'b1, 1'b0, beat, lat);
    check("post_reset_first", beat, {74'h124, 10'h055, 1'b1, 1'b0, 1'b0, 1'b0, lz_exp(65)});

    run_stream(200, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
